// File: rtl/cfg_chain_loader.sv
// cfg_chain_loader: writer side of a scan-style configuration flop chain.
// Accepts parallel words over valid/ready and shifts them MSB-first onto the
// chain head, one shift strobe per bit, until CHAIN_LEN bits are delivered.
// Optional macro CFG_LOADER_CRC_EN adds a CRC-16-CCITT readback signature of
// the old chain contents seen on chain_q while shifting.
module cfg_chain_loader #(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 1024,
  parameter int CNT_W     = 16
) (
  input  logic              C,
  input  logic              R,
  input  logic              start,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              chain_d,
  output logic              chain_shift,
  input  logic              chain_q,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bit_cnt
`ifdef CFG_LOADER_CRC_EN
  ,
  output logic [15:0]       crc
`endif
);

  localparam int BL_W = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t            state, nxt;
  logic [WORD_W-1:0] shreg;
  logic [BL_W-1:0]   bits_left;
  int                remain;

  // state register
  always_ff @(posedge C or posedge R) begin
    if (R) state <= IDLE;
    else   state <= nxt;
  end

  // next-state: last bit of a word goes to DONE only when the chain is full
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE: if (start) nxt = LOAD;
      LOAD:       if (in_valid) nxt = SHIFT;
      SHIFT: begin
        if (bits_left == BL_W'(1))
          nxt = (bit_cnt == CNT_W'(CHAIN_LEN - 1)) ? DONE : LOAD;
      end
      default:    nxt = IDLE;
    endcase
  end

  // outputs decoded from registered state and shift register only
  always_comb begin
    in_ready    = (state == LOAD);
    chain_shift = (state == SHIFT);
    chain_d     = (state == SHIFT) & shreg[WORD_W-1];
    busy        = (state == LOAD) | (state == SHIFT);
    done        = (state == DONE);
  end

  // bits still owed to the chain; clips the final partial word
  always_comb begin
    remain = CHAIN_LEN - int'(bit_cnt);
  end

  // datapath: word capture, MSB-first shifting, saturating bit counter
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      shreg     <= '0;
      bits_left <= '0;
      bit_cnt   <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (start) bit_cnt <= '0;
        LOAD: begin
          if (in_valid) begin
            shreg     <= in_data;
            bits_left <= (remain < WORD_W) ? BL_W'(remain) : BL_W'(WORD_W);
          end
        end
        SHIFT: begin
          shreg     <= shreg << 1;
          bits_left <= bits_left - BL_W'(1);
          if (bit_cnt < CNT_W'(CHAIN_LEN)) bit_cnt <= bit_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef CFG_LOADER_CRC_EN
  logic crc_fb;

  // feedback bit of the MSB-first CRC-16-CCITT
  always_comb begin
    crc_fb = crc[15] ^ chain_q;
  end

  // signature over chain tail bits; seeded on start, frozen outside SHIFT
  always_ff @(posedge C or posedge R) begin
    if (R) crc <= 16'hFFFF;
    else if ((state == IDLE || state == DONE) && start) crc <= 16'hFFFF;
    else if (state == SHIFT)
      crc <= {crc[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);
  end
`else
  // chain tail is not observed without the signature logic
  wire unused_chain_q = chain_q;
`endif

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Directed bench for cfg_chain_loader: two instances (CHAIN_LEN=8 and 6,
// WORD_W=4) driven from one linear initial block.
module tb_cfg_chain_loader;

  logic C = 1'b0;
  logic R = 1'b1;
  always #5 C = ~C;

  // instance A: WORD_W=4, CHAIN_LEN=8
  logic        start, in_valid, chain_q;
  logic [3:0]  in_data;
  logic        in_ready, chain_d, chain_shift, busy, done;
  logic [15:0] bit_cnt;
  // instance B: WORD_W=4, CHAIN_LEN=6
  logic        b_start, b_valid, b_q;
  logic [3:0]  b_data;
  logic        b_ready, b_d, b_shift, b_busy, b_done;
  logic [15:0] b_cnt;
`ifdef CFG_LOADER_CRC_EN
  logic [15:0] crc, b_crc;
`endif

  cfg_chain_loader #(.WORD_W(4), .CHAIN_LEN(8), .CNT_W(16)) dut_a (
    .C(C), .R(R), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .chain_d(chain_d), .chain_shift(chain_shift),
    .chain_q(chain_q), .busy(busy), .done(done), .bit_cnt(bit_cnt)
`ifdef CFG_LOADER_CRC_EN
    , .crc(crc)
`endif
  );

  cfg_chain_loader #(.WORD_W(4), .CHAIN_LEN(6), .CNT_W(16)) dut_b (
    .C(C), .R(R), .start(b_start), .in_data(b_data), .in_valid(b_valid),
    .in_ready(b_ready), .chain_d(b_d), .chain_shift(b_shift),
    .chain_q(b_q), .busy(b_busy), .done(b_done), .bit_cnt(b_cnt)
`ifdef CFG_LOADER_CRC_EN
    , .crc(b_crc)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge C);
    #1;
  endtask

  // start + words 0xA, 0x5 on instance A; optional stall before the first
  // word and optional start pulse during shift bit number pulse_bit.
  task automatic run_a5(input string tg, input int stall, input int pulse_bit);
    logic [3:0] words [2];
    logic [3:0] w_cur;
    words[0] = 4'hA;
    words[1] = 4'h5;
    in_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tg, " busy_after_start"}, 32'(busy), 32'd1);
    chk({tg, " done_cleared"}, 32'(done), 32'd0);
`ifdef CFG_LOADER_CRC_EN
    chk({tg, " crc_seed"}, 32'(crc), 32'hFFFF);
`endif
    for (int w = 0; w < 2; w++) begin
      chk({tg, " load_ready"}, 32'(in_ready), 32'd1);
      chk({tg, " load_noshift"}, 32'(chain_shift), 32'd0);
      chk({tg, " load_cnt"}, 32'(bit_cnt), 32'(4 * w));
      if (w == 0) begin
        for (int k = 0; k < stall; k++) begin
          tick();
          chk({tg, " stall_noshift"}, 32'(chain_shift), 32'd0);
          chk({tg, " stall_cnt"}, 32'(bit_cnt), 32'd0);
          chk({tg, " stall_ready"}, 32'(in_ready), 32'd1);
        end
      end
      in_valid = 1'b1;
      in_data  = words[w];
      w_cur    = words[w];
      tick();
      for (int i = 0; i < 4; i++) begin
        chk({tg, " shift_en"}, 32'(chain_shift), 32'd1);
        chk({tg, " shift_d"}, 32'(chain_d), 32'(w_cur[3-i]));
        chk({tg, " shift_cnt"}, 32'(bit_cnt), 32'(4 * w + i));
        chk({tg, " shift_notready"}, 32'(in_ready), 32'd0);
        if (4 * w + i == pulse_bit) start = 1'b1;
        tick();
        start = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk({tg, " done"}, 32'(done), 32'd1);
    chk({tg, " done_busy"}, 32'(busy), 32'd0);
    chk({tg, " done_ready"}, 32'(in_ready), 32'd0);
    chk({tg, " done_shift"}, 32'(chain_shift), 32'd0);
    chk({tg, " done_d"}, 32'(chain_d), 32'd0);
    chk({tg, " done_cnt"}, 32'(bit_cnt), 32'd8);
`ifdef CFG_LOADER_CRC_EN
    chk({tg, " crc_final"}, 32'(crc), 32'hE1F0);
`endif
    tick();
    chk({tg, " done_sticky"}, 32'(done), 32'd1);
    chk({tg, " cnt_hold"}, 32'(bit_cnt), 32'd8);
  endtask

  initial begin
    logic [5:0] b_bits;
    start = 0; in_valid = 0; in_data = 0; chain_q = 0;
    b_start = 0; b_valid = 0; b_data = 0; b_q = 0;

    // reset state
    #2;
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_shift", 32'(chain_shift), 32'd0);
    chk("rst_d", 32'(chain_d), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cnt", 32'(bit_cnt), 32'd0);
`ifdef CFG_LOADER_CRC_EN
    chk("rst_crc", 32'(crc), 32'hFFFF);
`endif
    @(negedge C);
    R = 1'b0;
    in_valid = 1'b1;   // ignored while idle
    tick();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_ready", 32'(in_ready), 32'd0);

    // 1: two full words
    run_a5("s1", 0, -1);
    // 3: five-cycle stall before the first word
    run_a5("s3", 5, -1);
    // 4: start pulsed mid-shift is ignored
    run_a5("s4", 0, 2);

    // 5: asynchronous reset at bit 3 of the first word
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 4'hA;
    tick();
    tick(); tick(); tick();
    chk("s5_pre_cnt", 32'(bit_cnt), 32'd3);
    chk("s5_pre_shift", 32'(chain_shift), 32'd1);
    #2;
    R = 1'b1;
    #1;
    chk("s5_rst_shift", 32'(chain_shift), 32'd0);
    chk("s5_rst_d", 32'(chain_d), 32'd0);
    chk("s5_rst_busy", 32'(busy), 32'd0);
    chk("s5_rst_cnt", 32'(bit_cnt), 32'd0);
    chk("s5_rst_ready", 32'(in_ready), 32'd0);
`ifdef CFG_LOADER_CRC_EN
    chk("s5_rst_crc", 32'(crc), 32'hFFFF);
`endif
    @(negedge C);
    R = 1'b0;
    in_valid = 1'b0;
    tick();
    run_a5("s5", 0, -1);

    // 2: CHAIN_LEN=6, low bits of 0xB discarded
    b_bits = 6'b110010;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    b_valid = 1'b1;
    b_data = 4'hC;
    chk("s2_ready", 32'(b_ready), 32'd1);
    tick();
    for (int i = 0; i < 6; i++) begin
      if (i == 4) begin
        chk("s2_bubble_shift", 32'(b_shift), 32'd0);
        chk("s2_bubble_cnt", 32'(b_cnt), 32'd4);
        b_data = 4'hB;
        tick();
      end
      chk("s2_shift_en", 32'(b_shift), 32'd1);
      chk("s2_shift_d", 32'(b_d), 32'(b_bits[5-i]));
      chk("s2_shift_cnt", 32'(b_cnt), 32'(i));
      tick();
    end
    b_valid = 1'b0;
    chk("s2_done", 32'(b_done), 32'd1);
    chk("s2_done_shift", 32'(b_shift), 32'd0);
    chk("s2_done_cnt", 32'(b_cnt), 32'd6);
    chk("s2_done_busy", 32'(b_busy), 32'd0);
    tick();
    chk("s2_after_shift", 32'(b_shift), 32'd0);
    chk("s2_after_cnt", 32'(b_cnt), 32'd6);

    // second start reseeds signature and clears done
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_done", 32'(done), 32'd0);
    chk("restart_cnt", 32'(bit_cnt), 32'd0);
`ifdef CFG_LOADER_CRC_EN
    chk("restart_crc", 32'(crc), 32'hFFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
